// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage feeding the IF/ID pipeline register. It owns the PC,
// issues instruction-memory reads and presents instr_o/npc_o qualified by
// valid_o. If IF/ID stalls while a fetch returns, a one-entry hold buffer
// keeps the instruction until IF/ID accepts it. Downstream redirects restart
// fetching at a new word-aligned PC. A halt stops fetching until reset.
//
// Ports:
//   CLK          system clock; all state updates on the rising edge
//   RST          synchronous active-high reset
//   imemREN      instruction read request
//   imemaddr     instruction read address (always equals the PC)
//   ihit         imemload is valid for imemaddr this cycle
//   imemload     instruction data from memory
//   stall        IF/ID cannot accept this cycle
//   redirect     taken branch/jump from a later stage
//   redirect_pc  redirect target; low two bits are dropped
//   halt         stop fetching permanently (until reset)
//   valid_o      instr_o/npc_o carry a fetched instruction
//   instr_o      fetched instruction (0 when not valid)
//   npc_o        PC+4 of the fetched instruction (0 when not valid)
//   fetch_count  instructions delivered (valid_o && !stall) since reset
// ----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] npc_o,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fetchState_t;

    fetchState_t state, stateNext;
    logic [31:0] pc, pcNext;
    logic [31:0] holdInstr, holdInstrNext;
    logic [31:0] holdNpc, holdNpcNext;
    logic        delivered;
    logic [31:0] pcPlus4;

    // Wraps modulo 2^32 by construction.
    assign pcPlus4  = pc + 32'd4;
    assign imemaddr = pc;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case/if tree leaves a variable unassigned (no latches).
        stateNext     = state;
        pcNext        = pc;
        holdInstrNext = holdInstr;
        holdNpcNext   = holdNpc;
        imemREN       = 1'b0;
        valid_o       = 1'b0;
        instr_o       = 32'd0;
        npc_o         = 32'd0;
        delivered     = 1'b0;

        case (state)
            FETCH: begin
                imemREN = 1'b1;
                if (halt) begin
                    // pc frozen; any returning data is dropped
                    stateNext = HALTED;
                end else if (redirect) begin
                    pcNext    = {redirect_pc[31:2], 2'b00};
                    stateNext = FETCH;
                end else if (ihit) begin
                    valid_o = 1'b1;
                    instr_o = imemload;
                    npc_o   = pcPlus4;
                    pcNext  = pcPlus4;
                    if (stall) begin
                        holdInstrNext = imemload;
                        holdNpcNext   = pcPlus4;
                        stateNext     = HOLD;
                    end else begin
                        delivered = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (halt) begin
                    stateNext = HALTED;
                end else if (redirect) begin
                    // held instruction is simply abandoned
                    pcNext    = {redirect_pc[31:2], 2'b00};
                    stateNext = FETCH;
                end else begin
                    valid_o = 1'b1;
                    instr_o = holdInstr;
                    npc_o   = holdNpc;
                    if (!stall) begin
                        delivered = 1'b1;
                        stateNext = FETCH;
                    end
                end
            end
            default: begin
                // HALTED: only reset leaves this state
                stateNext = HALTED;
            end
        endcase

        // Reset masks the request and the output qualifier in the same cycle.
        if (RST) begin
            imemREN   = 1'b0;
            valid_o   = 1'b0;
            instr_o   = 32'd0;
            npc_o     = 32'd0;
            delivered = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (RST) begin
            state       <= FETCH;
            pc          <= PC_INIT;
            holdInstr   <= 32'd0;
            holdNpc     <= 32'd0;
            fetch_count <= 32'd0;
        end else begin
            state     <= stateNext;
            pc        <= pcNext;
            holdInstr <= holdInstrNext;
            holdNpc   <= holdNpcNext;
            if (delivered) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//
// Bench for fetch_stage. Expected deliveries {instr, npc} are pushed to a
// scoreboard queue as stimulus is driven and popped whenever the DUT
// delivers (valid_o && !stall). A second instance with PC_INIT=FFFF_FFFC
// covers PC wrap. Inputs change just after the falling edge; outputs are
// sampled 2 time units later, well before the next rising edge.
// ----------------------------------------------------------------------------
module tb_fetch_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] npc;
    } item_t;

    logic        CLK = 1'b0;
    logic        RST, RST2;
    logic        ihit, stall, redirect, halt;
    logic [31:0] redirect_pc;
    logic [31:0] imemload, imemload2;
    logic        useOverride;
    logic [31:0] overrideData;

    logic        imemREN, valid_o;
    logic [31:0] imemaddr, instr_o, npc_o, fetch_count;
    logic        imemREN2, valid2;
    logic [31:0] imemaddr2, instr2, npc2, fetch_count2;

    item_t       sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] expCount = 32'd0;

    always #5 CLK = ~CLK;

    // Memory model: instruction word derived from the address being read.
    always_comb imemload  = useOverride ? overrideData : {16'hC0DE, imemaddr[15:0]};
    always_comb imemload2 = {16'hC0DE, imemaddr2[15:0]};

    fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .valid_o(valid_o), .instr_o(instr_o), .npc_o(npc_o),
        .fetch_count(fetch_count)
    );

    fetch_stage #(.PC_INIT(32'hFFFF_FFFC)) dutWrap (
        .CLK(CLK), .RST(RST2), .imemREN(imemREN2), .imemaddr(imemaddr2),
        .ihit(ihit), .imemload(imemload2), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .valid_o(valid2), .instr_o(instr2), .npc_o(npc2),
        .fetch_count(fetch_count2)
    );

    function automatic item_t mk(input logic [31:0] instr, input logic [31:0] npc);
        item_t it;
        it.instr = instr;
        it.npc   = npc;
        return it;
    endfunction

    task automatic expectDelivery(input logic [31:0] instr, input logic [31:0] npc);
        sb.push_back(mk(instr, npc));
        expCount = expCount + 32'd1;
    endtask

    // Sample point of the current cycle; scoreboard pops on delivery.
    task automatic sample();
        item_t e;
        #2;
        if (valid_o === 1'b1 && stall === 1'b0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_delivery: got instr=%h npc=%h, required no delivery", instr_o, npc_o);
            end else begin
                e = sb.pop_front();
                if (instr_o !== e.instr || npc_o !== e.npc) begin
                    errors++;
                    $display("FAIL delivery: got instr=%h npc=%h, required instr=%h npc=%h",
                             instr_o, npc_o, e.instr, e.npc);
                end
            end
        end
    endtask

    task automatic advance();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1; ihit = 1'b1; stall = 1'b0;
        sample();
        checks++;
        if (imemREN !== 1'b0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_outputs: got ren=%b valid=%b, required 0 0", imemREN, valid_o);
        end
        advance();
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expectDelivery({16'hC0DE, 16'(i * 4)}, 32'(i * 4 + 4));
            sample();
            if (i == 0) begin
                checks++;
                if (fetch_count !== 32'd0) begin
                    errors++;
                    $display("FAIL rst_count: got %0d, required 0", fetch_count);
                end
            end
            checks++;
            if (imemaddr !== 32'(i * 4)) begin
                errors++;
                $display("FAIL seq_addr: got %h, required %h", imemaddr, 32'(i * 4));
            end
            advance();
        end
        ihit = 1'b0;
        sample();
        checks++;
        if (fetch_count !== expCount || sb.size() != 0) begin
            errors++;
            $display("FAIL seq_count: got %0d pending=%0d, required %0d pending=0",
                     fetch_count, sb.size(), expCount);
        end
        advance();
    endtask

    task automatic test_hold();
        ihit = 1'b1; stall = 1'b1; useOverride = 1'b1; overrideData = 32'hAAAA_0001;
        sample();
        checks++;
        if (imemaddr !== 32'h10 || valid_o !== 1'b1 || instr_o !== 32'hAAAA_0001 || npc_o !== 32'h14) begin
            errors++;
            $display("FAIL stall_fetch: got addr=%h valid=%b instr=%h npc=%h, required 10 1 aaaa0001 14",
                     imemaddr, valid_o, instr_o, npc_o);
        end
        advance();
        ihit = 1'b0; useOverride = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample();
            checks++;
            if (imemREN !== 1'b0 || valid_o !== 1'b1 || instr_o !== 32'hAAAA_0001 || npc_o !== 32'h14) begin
                errors++;
                $display("FAIL hold_cycle%0d: got ren=%b valid=%b instr=%h npc=%h, required 0 1 aaaa0001 14",
                         k, imemREN, valid_o, instr_o, npc_o);
            end
            advance();
        end
        stall = 1'b0;
        expectDelivery(32'hAAAA_0001, 32'h14);
        sample();
        advance();
        sample();
        checks++;
        if (imemaddr !== 32'h14 || imemREN !== 1'b1 || fetch_count !== expCount || sb.size() != 0) begin
            errors++;
            $display("FAIL hold_release: got addr=%h ren=%b count=%0d, required 14 1 %0d",
                     imemaddr, imemREN, fetch_count, expCount);
        end
        advance();
    endtask

    task automatic test_redirect();
        ihit = 1'b1; redirect = 1'b1; redirect_pc = 32'h203;
        sample();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL redir_valid: got %b, required 0", valid_o);
        end
        advance();
        redirect = 1'b0; ihit = 1'b0;
        sample();
        checks++;
        if (imemaddr !== 32'h200 || fetch_count !== expCount) begin
            errors++;
            $display("FAIL redir_addr: got addr=%h count=%0d, required 200 %0d", imemaddr, fetch_count, expCount);
        end
        advance();
        // Fill the hold buffer, then redirect out of HOLD.
        ihit = 1'b1; stall = 1'b1;
        sample();
        advance();
        ihit = 1'b0; stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h300;
        sample();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL redir_hold_valid: got %b, required 0", valid_o);
        end
        advance();
        redirect = 1'b0;
        sample();
        checks++;
        if (imemaddr !== 32'h300 || valid_o !== 1'b0 || imemREN !== 1'b1 || fetch_count !== expCount) begin
            errors++;
            $display("FAIL redir_hold_discard: got addr=%h valid=%b ren=%b count=%0d, required 300 0 1 %0d",
                     imemaddr, valid_o, imemREN, fetch_count, expCount);
        end
        advance();
    endtask

    task automatic test_miss_wait();
        redirect = 1'b1; redirect_pc = 32'h40;
        sample();
        advance();
        redirect = 1'b0; ihit = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sample();
            checks++;
            if (imemREN !== 1'b1 || imemaddr !== 32'h40 || valid_o !== 1'b0 || fetch_count !== expCount) begin
                errors++;
                $display("FAIL miss_cycle%0d: got ren=%b addr=%h valid=%b count=%0d, required 1 40 0 %0d",
                         k, imemREN, imemaddr, valid_o, fetch_count, expCount);
            end
            advance();
        end
        ihit = 1'b1;
        expectDelivery(32'hC0DE_0040, 32'h44);
        sample();
        checks++;
        if (npc_o !== 32'h44) begin
            errors++;
            $display("FAIL miss_hit_npc: got %h, required 44", npc_o);
        end
        advance();
        ihit = 1'b0;
    endtask

    task automatic test_halt();
        ihit = 1'b1; halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h500;
        sample();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL halt_valid: got %b, required 0", valid_o);
        end
        advance();
        halt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            redirect = (k != 1);
            sample();
            checks++;
            if (imemREN !== 1'b0 || valid_o !== 1'b0 || instr_o !== 32'd0 || imemaddr !== 32'h44) begin
                errors++;
                $display("FAIL halted_cycle%0d: got ren=%b valid=%b instr=%h addr=%h, required 0 0 0 44",
                         k, imemREN, valid_o, instr_o, imemaddr);
            end
            advance();
        end
        redirect = 1'b0; ihit = 1'b0; RST = 1'b1;
        sample();
        advance();
        RST = 1'b0;
        expCount = 32'd0;
        sample();
        checks++;
        if (imemaddr !== 32'h0 || imemREN !== 1'b1 || fetch_count !== 32'd0) begin
            errors++;
            $display("FAIL halt_reset: got addr=%h ren=%b count=%0d, required 0 1 0", imemaddr, imemREN, fetch_count);
        end
        advance();
    endtask

    task automatic test_reset_in_hold();
        ihit = 1'b1; stall = 1'b1;
        sample();
        advance();
        ihit = 1'b0; RST = 1'b1;
        sample();
        checks++;
        if (valid_o !== 1'b0 || imemREN !== 1'b0) begin
            errors++;
            $display("FAIL rst_hold_mask: got valid=%b ren=%b, required 0 0", valid_o, imemREN);
        end
        advance();
        RST = 1'b0; stall = 1'b0;
        sample();
        checks++;
        if (valid_o !== 1'b0 || imemREN !== 1'b1 || imemaddr !== 32'h0) begin
            errors++;
            $display("FAIL rst_hold_fetch: got valid=%b ren=%b addr=%h, required 0 1 0", valid_o, imemREN, imemaddr);
        end
        advance();
        ihit = 1'b1;
        expectDelivery(32'hC0DE_0000, 32'h4);
        sample();
        advance();
        ihit = 1'b0;
    endtask

    task automatic test_wrap();
        RST = 1'b1; RST2 = 1'b0; ihit = 1'b1; stall = 1'b0;
        sample();
        checks++;
        if (imemaddr2 !== 32'hFFFF_FFFC || valid2 !== 1'b1 || npc2 !== 32'h0 || instr2 !== 32'hC0DE_FFFC) begin
            errors++;
            $display("FAIL wrap_fetch: got addr=%h valid=%b npc=%h instr=%h, required fffffffc 1 0 c0defffc",
                     imemaddr2, valid2, npc2, instr2);
        end
        advance();
        ihit = 1'b0;
        sample();
        checks++;
        if (imemaddr2 !== 32'h0 || fetch_count2 !== 32'd1) begin
            errors++;
            $display("FAIL wrap_next: got addr=%h count=%0d, required 0 1", imemaddr2, fetch_count2);
        end
        advance();
        RST2 = 1'b1;
    endtask

    initial begin
        RST = 1'b1; RST2 = 1'b1;
        ihit = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0;
        redirect_pc = 32'd0; useOverride = 1'b0; overrideData = 32'd0;
        @(negedge CLK);
        test_reset();
        test_hold();
        test_redirect();
        test_miss_wait();
        test_halt();
        test_reset_in_hold();
        test_wrap();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the PC and issues instruction-memory reads.
- Presents instr/npc with a valid qualifier to IF/ID, and absorbs IF/ID stalls with a one-entry hold buffer.
- Handles branch/jump redirects from downstream and stops fetching permanently on halt.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset

Ports:
CLK  in  1  system clock; all state updates on rising edge
RST  in  1  reset, synchronous, active-high
imemREN  out  1  instruction read request to icache/memory
imemaddr  out  32  instruction read address (word aligned)
ihit  in  1  icache returns imemload this cycle for the current imemaddr
imemload  in  32  instruction data, valid when ihit=1
stall  in  1  IF/ID cannot accept (IF/ID EN low)
redirect  in  1  taken branch/jump from a later stage
redirect_pc  in  32  target PC when redirect=1
halt  in  1  halt seen downstream; stop fetching
valid_o  out  1  instr_o/npc_o hold a fetched instruction this cycle
instr_o  out  32  fetched instruction, to IF/ID instr_i
npc_o  out  32  PC+4 of fetched instruction, to IF/ID npc_i
fetch_count  out  32  number of instructions delivered since reset

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (RST high at an edge):
  - pc=PC_INIT, state=FETCH, hold_instr=0, hold_npc=0, fetch_count=0.
  - While RST is high, imemREN=0 and valid_o=0 combinationally.
- An instruction is "delivered" in a cycle when valid_o=1 and stall=0. IF/ID loads exactly then.
- State FETCH:
  - imemREN=1, imemaddr=pc.
  - ihit=0: valid_o=0, no state change (wait; no timeout).
  - ihit=1, stall=0: valid_o=1, instr_o=imemload, npc_o=pc+4 (same cycle, combinational). pc<=pc+4; stay in FETCH.
  - ihit=1, stall=1: valid_o=1 with the same values. hold_instr<=imemload, hold_npc<=pc+4, pc<=pc+4; go to HOLD.
- State HOLD:
  - imemREN=0, valid_o=1, instr_o=hold_instr, npc_o=hold_npc.
  - stall=0: delivered; go to FETCH.
  - stall=1: remain in HOLD; outputs unchanged.
- State HALTED:
  - imemREN=0, valid_o=0, instr_o=0, npc_o=0.
  - Only RST exits this state. redirect is ignored.
- Redirect (in FETCH or HOLD):
  - valid_o forced to 0 this cycle; any ihit data and any held instruction are discarded; no delivery.
  - pc<={redirect_pc[31:2],2'b00}; next state FETCH.
  - imemREN may still be 1 this cycle; the returned data is dropped.
- Halt (in FETCH or HOLD):
  - valid_o forced to 0; next state HALTED; pc frozen.
  - Halt wins over a same-cycle redirect.
- Priority: RST > halt > redirect > normal.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. fetch_count increments by 1 per delivery and wraps.
- When valid_o=0, instr_o and npc_o are 0.
- imemaddr always equals pc. imemaddr[1:0] is always 0.
- Latency: fetch-to-IF/ID is zero additional cycles when ihit is 1-cycle. Maximum sustained throughput is 1 instruction/cycle.

Test Plan:
- Reset release with PC_INIT=0 and ihit tied 1, imemload=pc-derived pattern → delivered npc_o sequence 4,8,12,16; fetch_count=4 after 4 cycles; imemaddr 0,4,8,12.
- ihit=1 with stall=1 for 3 cycles at pc=0x10 (imemload=0xAAAA0001) → enters HOLD; imemREN=0; instr_o=0xAAAA0001 and npc_o=0x14 held for 3 cycles. Stall drops → one delivery, fetch_count+1, next imemaddr=0x14.
- redirect=1, redirect_pc=0x203 in the same cycle as ihit → valid_o=0, no delivery. Next cycle imemaddr=0x200; in-HOLD redirect also discards hold_instr.
- halt=1 with redirect=1 simultaneously → HALTED: imemREN=0, valid_o=0 thereafter, pc frozen. Redirect is ignored; RST returns imemaddr to PC_INIT.
- ihit=0 for 5 cycles at pc=0x40 → imemREN=1 and imemaddr=0x40 steady, valid_o=0, fetch_count unchanged. Then ihit=1 delivers npc_o=0x44.
- PC wrap with PC_INIT=32'hFFFF_FFFC → first delivery npc_o=0, next imemaddr=0. Synchronous RST asserted mid-HOLD → next cycle state FETCH, valid_o=0 during RST.
